// File: rtl/mpmc10_resp_fifo.sv
// Per-port read-response FIFO: buffers data+tag records from the controller core and
// presents them first-word-fall-through to the client with a valid/ack handshake.
module mpmc10_resp_fifo #(
    parameter int unsigned DW        = 256,
    parameter int unsigned TW        = 16,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned PROG_FULL = 27
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr,
    input  logic [DW-1:0]              din_dat,
    input  logic [TW-1:0]              din_tid,
    output logic                       resp_v,
    output logic [DW-1:0]              resp_dat,
    output logic [TW-1:0]              resp_tid,
    input  logic                       resp_ack,
    output logic                       full,
    output logic                       almost_full,
    output logic                       prog_full,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW+TW-1:0] mem [DEPTH];
    logic [DW+TW-1:0] head;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, almost_full_q, prog_full_q;
    logic             overflow_q, underflow_q;
    logic             push, pop;

    // A push is judged against the registered full flag only, so a same-cycle pop
    // never makes room for it.
    assign push = wr && !full_q;
    assign pop  = resp_ack && resp_v;

    assign resp_v   = (cnt_q != '0);
    assign head     = mem[rd_ptr_q];
    assign resp_dat = resp_v ? head[DW+TW-1:TW] : '0;
    assign resp_tid = resp_v ? head[TW-1:0] : '0;

    assign full        = full_q;
    assign almost_full = almost_full_q;
    assign prog_full   = prog_full_q;
    assign cnt         = cnt_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {din_dat, din_tid};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            prog_full_q   <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q         <= cnt_d;
            full_q        <= (cnt_d == CW'(DEPTH));
            almost_full_q <= (cnt_d >= CW'(DEPTH - 1));
            prog_full_q   <= (cnt_d >= CW'(PROG_FULL));
            // A fresh error wins over a same-cycle clear.
            overflow_q    <= (wr && full_q) || (overflow_q && !clr_err);
            underflow_q   <= (resp_ack && !resp_v) || (underflow_q && !clr_err);
        end
    end

endmodule
